// File: rtl/z80_int_ctrl_pkg.sv
// Shared types and constants for the Z80 interrupt-control unit.
package z80_int_pkg;

  // Handshake state toward the sequencer.
  typedef enum logic {
    INT_RUN = 1'b0,
    INT_REQ = 1'b1
  } int_state_t;

  // Interrupt mode encodings.
  localparam logic [1:0] IM0 = 2'd0;
  localparam logic [1:0] IM1 = 2'd1;
  localparam logic [1:0] IM2 = 2'd2;

  // The EI shadow counter is sized for the largest supported delay.
  localparam int EI_DELAY_MAX = 7;
  localparam int CNT_W        = $clog2(EI_DELAY_MAX + 1);

endpackage

// File: rtl/z80_int_ctrl_if.sv
// Sequencer <-> interrupt-control handshake bundle.
interface z80_int_ctrl_if #(
  parameter int NUM_IRQ = 1
);
  localparam int IDW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  logic               insn_done;
  logic               op_ei;
  logic               op_di;
  logic               op_retn;
  logic               op_im;
  logic [1:0]         im_val;
  logic               nmi;
  logic [NUM_IRQ-1:0] irq;
  logic               int_ack;

  logic               iff1;
  logic               iff2;
  logic [1:0]         im;
  logic               ei_shadow;
  logic               int_req;
  logic               int_nmi;
  logic [IDW-1:0]     int_id;
  logic               proto_err;

  // Sequencer / request-source side.
  modport master (
    output insn_done, op_ei, op_di, op_retn, op_im, im_val, nmi, irq, int_ack,
    input  iff1, iff2, im, ei_shadow, int_req, int_nmi, int_id, proto_err
  );

  // Interrupt controller side.
  modport slave (
    input  insn_done, op_ei, op_di, op_retn, op_im, im_val, nmi, irq, int_ack,
    output iff1, iff2, im, ei_shadow, int_req, int_nmi, int_id, proto_err
  );
endinterface

// File: rtl/z80_int_ctrl_prio_enc.sv
// Lowest-index-first priority encoder with an any-valid flag.
module z80_int_prio_enc #(
  parameter int N   = 1,
  parameter int IDW = 1
) (
  input  logic [N-1:0]   i_req,
  output logic [IDW-1:0] o_id,
  output logic           o_any
);

  // Scan from the top down so the lowest set index is the last to win.
  always_comb begin
    o_id  = '0;
    o_any = |i_req;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) o_id = IDW'(i);
    end
  end

endmodule

// File: rtl/z80_int_ctrl.sv
// Z80 interrupt control: IFF1/IFF2, IM, post-EI shadow, NMI edge capture,
// maskable prioritisation and the request/ack handshake to the sequencer.
module z80_int_ctrl
  import z80_int_pkg::*;
#(
  parameter int NUM_IRQ  = 1,
  parameter int EI_DELAY = 1
) (
  input  logic          clk,
  input  logic          reset,
  z80_int_ctrl_if.slave bus
);

  localparam int IDW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam logic [CNT_W-1:0] EI_LOAD = CNT_W'(EI_DELAY);

  int_state_t       r_state;
  logic             r_iff1;
  logic             r_iff2;
  logic [1:0]       r_im;
  logic [CNT_W-1:0] r_cnt;
  logic             r_nmi_prev;
  logic             r_nmi_pend;
  logic             r_int_nmi;
  logic [IDW-1:0]   r_int_id;
  logic             r_proto_err;

  int_state_t       w_state;
  logic             w_iff1;
  logic             w_iff2;
  logic [1:0]       w_im;
  logic [CNT_W-1:0] w_cnt;
  logic             w_nmi_pend;
  logic             w_int_nmi;
  logic [IDW-1:0]   w_int_id;
  logic             w_proto_err;

  logic             w_nmi_edge;
  logic             w_irq_any;
  logic [IDW-1:0]   w_irq_id;
  logic             w_mask_elig;

  z80_int_prio_enc #(
    .N   (NUM_IRQ),
    .IDW (IDW)
  ) u_prio (
    .i_req (bus.irq),
    .o_id  (w_irq_id),
    .o_any (w_irq_any)
  );

  assign w_nmi_edge = bus.nmi & ~r_nmi_prev;

  // Next-state: op effects at boundaries, eligibility, handshake and ack.
  always_comb begin
    w_state     = r_state;
    w_iff1      = r_iff1;
    w_iff2      = r_iff2;
    w_im        = r_im;
    w_cnt       = r_cnt;
    w_nmi_pend  = r_nmi_pend | w_nmi_edge;
    w_int_nmi   = r_int_nmi;
    w_int_id    = r_int_id;
    w_proto_err = r_proto_err;
    w_mask_elig = 1'b0;

    case (r_state)
      INT_RUN: begin
        if (bus.insn_done) begin
          // Only the highest-priority op of the retiring instruction applies.
          if (bus.op_di) begin
            w_iff1 = 1'b0;
            w_iff2 = 1'b0;
            w_cnt  = '0;
          end else if (bus.op_ei) begin
            w_iff1 = 1'b1;
            w_iff2 = 1'b1;
            w_cnt  = EI_LOAD;
          end else if (bus.op_retn) begin
            w_iff1 = r_iff2;
          end else begin
            if (bus.op_im && (bus.im_val != 2'd3)) w_im = bus.im_val;
            if (r_cnt != '0) w_cnt = r_cnt - CNT_W'(1);
          end

          // Eligibility is judged on the values this boundary produces.
          w_mask_elig = w_iff1 && (w_cnt == '0) && w_irq_any;
          if (w_nmi_pend || w_mask_elig) begin
            w_state   = INT_REQ;
            w_int_nmi = w_nmi_pend;
            w_int_id  = w_irq_id;
          end
        end
      end

      INT_REQ: begin
        // A retire while a request is outstanding is a sequencer bug.
        if (bus.insn_done) w_proto_err = 1'b1;
        if (bus.int_ack) begin
          w_state = INT_RUN;
          if (r_int_nmi) begin
            w_iff1     = 1'b0;
            w_nmi_pend = w_nmi_edge;
          end else begin
            w_iff1 = 1'b0;
            w_iff2 = 1'b0;
          end
        end
      end

      default: w_state = INT_RUN;
    endcase
  end

  // All controller state, asynchronously reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= INT_RUN;
      r_iff1      <= 1'b0;
      r_iff2      <= 1'b0;
      r_im        <= IM0;
      r_cnt       <= '0;
      r_nmi_prev  <= 1'b0;
      r_nmi_pend  <= 1'b0;
      r_int_nmi   <= 1'b0;
      r_int_id    <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_iff1      <= w_iff1;
      r_iff2      <= w_iff2;
      r_im        <= w_im;
      r_cnt       <= w_cnt;
      r_nmi_prev  <= bus.nmi;
      r_nmi_pend  <= w_nmi_pend;
      r_int_nmi   <= w_int_nmi;
      r_int_id    <= w_int_id;
      r_proto_err <= w_proto_err;
    end
  end

  assign bus.iff1      = r_iff1;
  assign bus.iff2      = r_iff2;
  assign bus.im        = r_im;
  assign bus.ei_shadow = (r_cnt != '0);
  assign bus.int_req   = (r_state == INT_REQ);
  assign bus.int_nmi   = r_int_nmi;
  assign bus.int_id    = r_int_id;
  assign bus.proto_err = r_proto_err;

endmodule

// File: tb/tb_z80_int_ctrl.sv
// Directed vector bench for z80_int_ctrl (NUM_IRQ=4, EI_DELAY=1).
module tb_z80_int_ctrl;

  localparam int NIRQ = 4;

  localparam logic [3:0] OP_NONE = 4'b0000;
  localparam logic [3:0] OP_DI   = 4'b1000;
  localparam logic [3:0] OP_EI   = 4'b0100;
  localparam logic [3:0] OP_RETN = 4'b0010;
  localparam logic [3:0] OP_IM   = 4'b0001;

  typedef struct {
    logic       done;
    logic [3:0] op;     // {di, ei, retn, im}
    logic [1:0] imv;
    logic       nmi;
    logic [3:0] irq;
    logic       ack;
    logic       e_iff1;
    logic       e_iff2;
    logic [1:0] e_im;
    logic       e_sh;
    logic       e_req;
    logic       e_nmi;
    logic [1:0] e_id;
    logic       e_perr;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  z80_int_ctrl_if #(.NUM_IRQ(NIRQ)) bus ();

  z80_int_ctrl #(
    .NUM_IRQ  (NIRQ),
    .EI_DELAY (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic done, input logic [3:0] op, input logic [1:0] imv,
    input logic nmi, input logic [3:0] irq, input logic ack,
    input logic e_iff1, input logic e_iff2, input logic [1:0] e_im,
    input logic e_sh, input logic e_req, input logic e_nmi,
    input logic [1:0] e_id, input logic e_perr);
    vec_t v;
    v.done = done; v.op = op; v.imv = imv; v.nmi = nmi; v.irq = irq; v.ack = ack;
    v.e_iff1 = e_iff1; v.e_iff2 = e_iff2; v.e_im = e_im; v.e_sh = e_sh;
    v.e_req = e_req; v.e_nmi = e_nmi; v.e_id = e_id; v.e_perr = e_perr;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.insn_done = v.done;
    bus.op_di     = v.op[3];
    bus.op_ei     = v.op[2];
    bus.op_retn   = v.op[1];
    bus.op_im     = v.op[0];
    bus.im_val    = v.imv;
    bus.nmi       = v.nmi;
    bus.irq       = v.irq;
    bus.int_ack   = v.ack;
  endtask

  task automatic check_all(input vec_t v, input int idx);
    chk("iff1",      idx, 32'(bus.iff1),      32'(v.e_iff1));
    chk("iff2",      idx, 32'(bus.iff2),      32'(v.e_iff2));
    chk("im",        idx, 32'(bus.im),        32'(v.e_im));
    chk("ei_shadow", idx, 32'(bus.ei_shadow), 32'(v.e_sh));
    chk("int_req",   idx, 32'(bus.int_req),   32'(v.e_req));
    chk("int_nmi",   idx, 32'(bus.int_nmi),   32'(v.e_nmi));
    chk("int_id",    idx, 32'(bus.int_id),    32'(v.e_id));
    chk("proto_err", idx, 32'(bus.proto_err), 32'(v.e_perr));
  endtask

  vec_t tbl[$];
  vec_t idle0;
  vec_t v;

  initial begin
    checks = 0;
    errors = 0;
    idle0 = mk(0, OP_NONE, 2'd0, 0, 4'b0000, 0, 0,0,2'd0, 0,0,0,2'd0, 0);
    drive(idle0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    //          done op       imv  nmi irq      ack  iff1 iff2 im   sh req nmi id  perr
    // EI with a held 4'b1100 request: shadow blocks the EI boundary itself.
    tbl.push_back(mk(0, OP_NONE, 2'd0, 0, 4'b0000, 0,  0,0,2'd0, 0,0,0,2'd0, 0));
    tbl.push_back(mk(1, OP_EI,   2'd0, 0, 4'b1100, 0,  1,1,2'd0, 1,0,0,2'd0, 0));
    tbl.push_back(mk(1, OP_NONE, 2'd0, 0, 4'b1100, 0,  1,1,2'd0, 0,1,0,2'd2, 0));
    tbl.push_back(mk(0, OP_NONE, 2'd0, 0, 4'b0010, 0,  1,1,2'd0, 0,1,0,2'd2, 0));
    tbl.push_back(mk(0, OP_NONE, 2'd0, 0, 4'b0010, 1,  0,0,2'd0, 0,0,0,2'd2, 0));
    tbl.push_back(mk(1, OP_NONE, 2'd0, 0, 4'b0010, 0,  0,0,2'd0, 0,0,0,2'd2, 0));
    // Maskable on line 1, acked, then masked.
    tbl.push_back(mk(1, OP_EI,   2'd0, 0, 4'b0010, 0,  1,1,2'd0, 1,0,0,2'd2, 0));
    tbl.push_back(mk(1, OP_NONE, 2'd0, 0, 4'b0010, 0,  1,1,2'd0, 0,1,0,2'd1, 0));
    tbl.push_back(mk(0, OP_NONE, 2'd0, 0, 4'b0010, 1,  0,0,2'd0, 0,0,0,2'd1, 0));
    tbl.push_back(mk(1, OP_NONE, 2'd0, 0, 4'b0010, 0,  0,0,2'd0, 0,0,0,2'd1, 0));
    // EI, RETN (counter kept), NMI edge on the retire boundary.
    tbl.push_back(mk(1, OP_EI,   2'd0, 0, 4'b0000, 0,  1,1,2'd0, 1,0,0,2'd1, 0));
    tbl.push_back(mk(1, OP_RETN, 2'd0, 0, 4'b0000, 0,  1,1,2'd0, 1,0,0,2'd1, 0));
    tbl.push_back(mk(1, OP_NONE, 2'd0, 1, 4'b0000, 0,  1,1,2'd0, 0,1,1,2'd0, 0));
    tbl.push_back(mk(0, OP_NONE, 2'd0, 1, 4'b0000, 0,  1,1,2'd0, 0,1,1,2'd0, 0));
    tbl.push_back(mk(0, OP_NONE, 2'd0, 1, 4'b0000, 1,  0,1,2'd0, 0,0,1,2'd0, 0));
    tbl.push_back(mk(1, OP_RETN, 2'd0, 0, 4'b0000, 0,  1,1,2'd0, 0,0,1,2'd0, 0));
    // DI beats EI; IM 2 then IM 3 (ignored).
    tbl.push_back(mk(1, OP_DI|OP_EI, 2'd0, 0, 4'b0000, 0,  0,0,2'd0, 0,0,1,2'd0, 0));
    tbl.push_back(mk(1, OP_IM,   2'd2, 0, 4'b0000, 0,  0,0,2'd2, 0,0,1,2'd0, 0));
    tbl.push_back(mk(1, OP_IM,   2'd3, 0, 4'b0000, 0,  0,0,2'd2, 0,0,1,2'd0, 0));
    // NMI edge during a held maskable request is taken after the ack.
    tbl.push_back(mk(1, OP_EI,   2'd0, 0, 4'b0001, 0,  1,1,2'd2, 1,0,1,2'd0, 0));
    tbl.push_back(mk(1, OP_NONE, 2'd0, 0, 4'b0001, 0,  1,1,2'd2, 0,1,0,2'd0, 0));
    tbl.push_back(mk(0, OP_NONE, 2'd0, 1, 4'b0001, 0,  1,1,2'd2, 0,1,0,2'd0, 0));
    tbl.push_back(mk(0, OP_NONE, 2'd0, 1, 4'b0001, 1,  0,0,2'd2, 0,0,0,2'd0, 0));
    tbl.push_back(mk(1, OP_NONE, 2'd0, 1, 4'b0001, 0,  0,0,2'd2, 0,1,1,2'd0, 0));
    tbl.push_back(mk(0, OP_NONE, 2'd0, 0, 4'b0001, 1,  0,0,2'd2, 0,0,1,2'd0, 0));
    // Retire during REQ: sticky proto_err, op dropped; NMI edge left pending.
    tbl.push_back(mk(1, OP_EI,   2'd0, 0, 4'b1000, 0,  1,1,2'd2, 1,0,1,2'd0, 0));
    tbl.push_back(mk(1, OP_NONE, 2'd0, 0, 4'b1000, 0,  1,1,2'd2, 0,1,0,2'd3, 0));
    tbl.push_back(mk(1, OP_DI,   2'd0, 0, 4'b1000, 0,  1,1,2'd2, 0,1,0,2'd3, 1));
    tbl.push_back(mk(1, OP_IM,   2'd0, 1, 4'b1000, 0,  1,1,2'd2, 0,1,0,2'd3, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      @(posedge clk);
      #1;
      check_all(tbl[i], i);
    end

    // Asynchronous reset in the middle of REQ, away from any clock edge.
    @(negedge clk);
    drive(idle0);
    #1;
    reset = 1'b1;
    #1;
    check_all(idle0, 100);
    @(negedge clk);
    reset = 1'b0;

    // The NMI that was pending before reset must not produce a request.
    v = mk(1, OP_NONE, 2'd0, 0, 4'b0000, 0,  0,0,2'd0, 0,0,0,2'd0, 0);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    check_all(v, 101);

    // Ack while idle is ignored.
    v = mk(0, OP_NONE, 2'd0, 0, 4'b1111, 1,  0,0,2'd0, 0,0,0,2'd0, 0);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    check_all(v, 102);

    @(negedge clk);
    drive(idle0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
